// File: rtl/variable_table_mp.sv
// variable_table_mp: one-bit-per-variable assignment table for the SAT solver core.
// Serves NUM_READ_PORTS registered lookups per cycle, single-cycle flips from the
// solver, a shared host (AXI-style) load/readback port, a self-sequenced
// initialisation sweep and a saturating flip counter.
// Optional feature macro: RANDOM_INIT_EN (sweep fill bit from a 16-bit LFSR
// instead of the constant INIT_VALUE).
module variable_table_mp #(
   parameter int            VARIABLE_ADDRESS_WIDTH = 11,
   parameter int            NUM_READ_PORTS         = 4,
   parameter logic          INIT_VALUE             = 1'b0,
   parameter logic [15:0]   LFSR_SEED              = 16'hACE1
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic [NUM_READ_PORTS-1:0]                       rd_en_i,
   input  logic [NUM_READ_PORTS*VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_i,
   output logic [NUM_READ_PORTS-1:0]                       rd_data_o,
   input  logic                                            flip_en_i,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0]               flip_addr_i,
   output logic                                            flip_ready_o,
   input  logic                                            init_start_i,
   output logic                                            init_busy_o,
   output logic                                            init_done_o,
   output logic [31:0]                                     flip_count_o,
   input  logic                                            axi_en_i,
   input  logic                                            axi_wr_en_i,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0]               axi_addr_i,
   input  logic                                            axi_data_i,
   output logic                                            axi_data_o
);

   localparam int W     = VARIABLE_ADDRESS_WIDTH;
   localparam int DEPTH = 2**W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   logic [0:0]   state_q;
   logic [W-1:0] sweep_addr_q;
   logic         init_done_q;
   logic [31:0]  flip_count_q;
   logic         mem_q [DEPTH];

   logic sweep_busy;
   logic flip_accept;
   logic axi_wr;
   logic sweep_last;
   logic fill_bit;

   assign sweep_busy  = (state_q == ST_SWEEP);
   assign flip_accept = flip_en_i & ~sweep_busy;
   assign axi_wr      = axi_en_i & axi_wr_en_i & ~sweep_busy;
   assign sweep_last  = &sweep_addr_q;

`ifdef RANDOM_INIT_EN
   logic [15:0] lfsr_q;
   logic        lfsr_fb;

   // x^16+x^14+x^13+x^11+1 taps expressed on the right-shifting register
   assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign fill_bit = lfsr_q[0];

   // LFSR advances once per sweep write; only reset reseeds it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else if (sweep_busy) begin
         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      end
   end
`else
   assign fill_bit = INIT_VALUE;
`endif

   // Sweep/idle sequencing, done pulse and saturating flip counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_SWEEP;
         sweep_addr_q <= '0;
         init_done_q  <= 1'b0;
         flip_count_q <= '0;
      end else begin
         init_done_q <= 1'b0;
         case (state_q)
            ST_SWEEP: begin
               sweep_addr_q <= sweep_addr_q + 1'b1;
               if (sweep_last) begin
                  state_q     <= ST_IDLE;
                  init_done_q <= 1'b1;
               end
            end
            default: begin
               if (flip_accept && (flip_count_q != 32'hFFFF_FFFF)) begin
                  flip_count_q <= flip_count_q + 32'd1;
               end
               // a new sweep clears the counter even if a flip lands on the same edge
               if (init_start_i) begin
                  state_q      <= ST_SWEEP;
                  sweep_addr_q <= '0;
                  flip_count_q <= '0;
               end
            end
         endcase
      end
   end

   // Table storage: sweep owns the array; otherwise host write overrides a same-address flip
   always_ff @(posedge clk_i) begin
      if (sweep_busy) begin
         mem_q[sweep_addr_q] <= fill_bit;
      end else begin
         if (flip_accept) begin
            mem_q[flip_addr_i] <= ~mem_q[flip_addr_i];
         end
         if (axi_wr) begin
            mem_q[axi_addr_i] <= axi_data_i;
         end
      end
   end

   // Registered read-first lookups; each port holds its last value when not enabled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data_o  <= '0;
         axi_data_o <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_READ_PORTS; k++) begin
            if (rd_en_i[k]) begin
               rd_data_o[k] <= mem_q[rd_addr_i[k*W +: W]];
            end
         end
         if (axi_en_i) begin
            axi_data_o <= mem_q[axi_addr_i];
         end
      end
   end

   assign init_busy_o  = sweep_busy;
   assign flip_ready_o = ~sweep_busy;
   assign init_done_o  = init_done_q;
   assign flip_count_o = flip_count_q;

endmodule

// File: tb/tb_variable_table_mp.sv
// Scoreboard bench for variable_table_mp (4-bit addresses, 2 read ports).
module tb_variable_table_mp;

   localparam int AW    = 4;
   localparam int NP    = 2;
   localparam int DEPTH = 16;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic [NP-1:0]    rd_en_i;
   logic [NP*AW-1:0] rd_addr_i;
   logic [NP-1:0]    rd_data_o;
   logic             flip_en_i;
   logic [AW-1:0]    flip_addr_i;
   logic             flip_ready_o;
   logic             init_start_i;
   logic             init_busy_o;
   logic             init_done_o;
   logic [31:0]      flip_count_o;
   logic             axi_en_i;
   logic             axi_wr_en_i;
   logic [AW-1:0]    axi_addr_i;
   logic             axi_data_i;
   logic             axi_data_o;

   variable_table_mp #(
      .VARIABLE_ADDRESS_WIDTH(AW),
      .NUM_READ_PORTS(NP),
      .INIT_VALUE(1'b0),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
      .flip_en_i(flip_en_i), .flip_addr_i(flip_addr_i), .flip_ready_o(flip_ready_o),
      .init_start_i(init_start_i), .init_busy_o(init_busy_o), .init_done_o(init_done_o),
      .flip_count_o(flip_count_o),
      .axi_en_i(axi_en_i), .axi_wr_en_i(axi_wr_en_i), .axi_addr_i(axi_addr_i),
      .axi_data_i(axi_data_i), .axi_data_o(axi_data_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   bit          m_mem [DEPTH];
   int          sweep_left;
   bit          m_done;
   logic [31:0] m_count;
   logic [15:0] m_lfsr;

   bit q_rd0 [$];
   bit q_rd1 [$];
   bit q_axi [$];

   logic [2:0] vld_p0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic get_fill(output bit b);
`ifdef RANDOM_INIT_EN
      b = m_lfsr[0];
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
      b = 1'b0;
`endif
   endtask

   // which read ports were issued at the last edge
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) vld_p0 <= '0;
      else       vld_p0 <= {axi_en_i, rd_en_i};
   end

   // monitor: compare every registered read against the value queued at issue
   always @(negedge clk_i) begin
      bit e;
      if (vld_p0[0] === 1'b1) begin
         if (q_rd0.size() == 0) check("rd0_underflow", 32'd1, 32'd0);
         else begin e = q_rd0.pop_front(); check("rd_data0", 32'(rd_data_o[0]), 32'(e)); end
      end
      if (vld_p0[1] === 1'b1) begin
         if (q_rd1.size() == 0) check("rd1_underflow", 32'd1, 32'd0);
         else begin e = q_rd1.pop_front(); check("rd_data1", 32'(rd_data_o[1]), 32'(e)); end
      end
      if (vld_p0[2] === 1'b1) begin
         if (q_axi.size() == 0) check("axi_underflow", 32'd1, 32'd0);
         else begin e = q_axi.pop_front(); check("axi_data", 32'(axi_data_o), 32'(e)); end
      end
   end

   task automatic idle_inputs();
      rd_en_i = '0; rd_addr_i = '0; flip_en_i = 1'b0; flip_addr_i = '0;
      init_start_i = 1'b0; axi_en_i = 1'b0; axi_wr_en_i = 1'b0; axi_addr_i = '0; axi_data_i = 1'b0;
   endtask

   // one clock: queue expected reads, advance model, then check control outputs
   task automatic tick();
      bit f;
      bit nd;
      if (rd_en_i[0]) q_rd0.push_back(m_mem[rd_addr_i[3:0]]);
      if (rd_en_i[1]) q_rd1.push_back(m_mem[rd_addr_i[7:4]]);
      if (axi_en_i)   q_axi.push_back(m_mem[axi_addr_i]);
      nd = 1'b0;
      if (sweep_left > 0) begin
         get_fill(f);
         m_mem[DEPTH - sweep_left] = f;
         sweep_left--;
         nd = (sweep_left == 0);
      end else begin
         if (flip_en_i) begin
            m_mem[flip_addr_i] = ~m_mem[flip_addr_i];
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
         end
         if (axi_en_i && axi_wr_en_i) m_mem[axi_addr_i] = axi_data_i;
         if (init_start_i) begin
            sweep_left = DEPTH;
            m_count    = 0;
         end
      end
      m_done = nd;
      @(posedge clk_i);
      #1;
      check("init_busy", 32'(init_busy_o), 32'(sweep_left > 0));
      check("flip_ready", 32'(flip_ready_o), 32'(sweep_left == 0));
      check("init_done", 32'(init_done_o), 32'(m_done));
      check("flip_count", flip_count_o, m_count);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      #2;
      rst_i = 1'b1;
      q_rd0.delete(); q_rd1.delete(); q_axi.delete();
      sweep_left = DEPTH; m_count = 0; m_done = 1'b0; m_lfsr = 16'hACE1;
      #1;
      check("rst_rd_data", 32'(rd_data_o), 32'd0);
      check("rst_axi_data", 32'(axi_data_o), 32'd0);
      check("rst_flip_count", flip_count_o, 32'd0);
      check("rst_init_busy", 32'(init_busy_o), 32'd1);
      check("rst_init_done", 32'(init_done_o), 32'd0);
      check("rst_flip_ready", 32'(flip_ready_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         idle_inputs();
         rd_en_i   = 2'b11;
         rd_addr_i = {4'(DEPTH - 1 - a), 4'(a)};
         axi_en_i  = 1'b1;
         axi_addr_i = 4'(a);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 1'b0;
      @(negedge clk_i);

      // power-up sweep, then full readback
      do_reset();
      for (int i = 0; i < DEPTH; i++) tick();
      tick();
      read_all();

      // host write then two flips of the same variable
      axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 4'd5; axi_data_i = 1'b1; tick();
      idle_inputs(); flip_en_i = 1'b1; flip_addr_i = 4'd5; tick(); tick();
      idle_inputs(); rd_en_i = 2'b01; rd_addr_i = {4'd0, 4'd5}; tick();
      idle_inputs(); tick();
      check("count_after_two_flips", flip_count_o, 32'd2);

      // host write collides with flip at the same address; concurrent read sees old value
      axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 4'd3; axi_data_i = 1'b1; tick();
      idle_inputs();
      axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 4'd3; axi_data_i = 1'b0;
      flip_en_i = 1'b1; flip_addr_i = 4'd3;
      rd_en_i = 2'b11; rd_addr_i = {4'd3, 4'd3};
      tick();
      idle_inputs(); rd_en_i = 2'b11; rd_addr_i = {4'd3, 4'd3}; tick();
      idle_inputs(); tick();
      check("count_after_collision", flip_count_o, 32'd3);

      // re-init with flips hammered throughout the sweep
      init_start_i = 1'b1; tick();
      for (int i = 0; i < DEPTH; i++) begin
         idle_inputs();
         flip_en_i = 1'b1; flip_addr_i = 4'(i);
         init_start_i = 1'b1;
         axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 4'(i); axi_data_i = 1'b1;
         tick();
      end
      idle_inputs(); tick();
      check("count_after_sweep", flip_count_o, 32'd0);
      read_all();

      // reset in the middle of a sweep
      init_start_i = 1'b1; tick();
      idle_inputs();
      for (int i = 0; i < 8; i++) tick();
      do_reset();
      for (int i = 0; i < DEPTH; i++) tick();
      tick();
      read_all();

      // randomized traffic, including occasional re-init
      for (int i = 0; i < 600; i++) begin
         rd_en_i      = 2'($urandom);
         rd_addr_i    = 8'($urandom);
         flip_en_i    = 1'($urandom);
         flip_addr_i  = 4'($urandom);
         axi_en_i     = 1'($urandom);
         axi_wr_en_i  = 1'($urandom);
         axi_addr_i   = ($urandom_range(0, 3) == 0) ? flip_addr_i : 4'($urandom);
         axi_data_i   = 1'($urandom);
         init_start_i = ($urandom_range(0, 79) == 0);
         tick();
      end
      idle_inputs();
      for (int i = 0; i < DEPTH + 1; i++) tick();
      read_all();
      tick();
      tick();
      check("queues_drained", 32'(q_rd0.size() + q_rd1.size() + q_axi.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
